down_counter_timer: RTL and testbench

//   Loadable down-counter / countdown timer: the down-counting counterpart of the

---
 rtl/down_counter_timer_if.sv | 22 ++
 rtl/down_counter_timer.sv | 94 +++++++++
 tb/tb_down_counter_timer.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/down_counter_timer_if.sv
// Control/status bundle for down_counter_timer: load/enable strobes in, count and state flags out.
interface down_counter_timer_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic             load;
    logic [WIDTH-1:0] load_value;
    logic [WIDTH-1:0] count_q;
    logic             running;
    logic             done;
    logic             tc;

    modport master (
        output enable, load, load_value,
        input  count_q, running, done, tc
    );

    modport slave (
        input  enable, load, load_value,
        output count_q, running, done, tc
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter / countdown timer with IDLE/RUN/EXPIRED states and a one-cycle tc pulse.
// Define AUTO_RELOAD_EN to reload from the last loaded value at terminal count instead of expiring.
module down_counter_timer #(
    parameter int WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    down_counter_timer_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic             r_running;
    logic             r_done;
    logic             r_tc;

    // State machine, count register and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_count   <= CNT_ZERO;
            r_reload  <= CNT_ZERO;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_tc      <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (bus.load) begin
                r_count  <= bus.load_value;
                r_reload <= bus.load_value;
                if (bus.load_value != CNT_ZERO) begin
                    r_state   <= ST_RUN;
                    r_running <= 1'b1;
                    r_done    <= 1'b0;
                end else begin
                    r_state   <= ST_EXPIRED;
                    r_running <= 1'b0;
                    r_done    <= 1'b1;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_count <= r_count;
                    end
                    ST_RUN: begin
                        if (bus.enable) begin
                            if (r_count == CNT_ONE) begin
                                r_tc <= 1'b1;
`ifdef AUTO_RELOAD_EN
                                r_count <= r_reload;
`else
                                r_count   <= CNT_ZERO;
                                r_state   <= ST_EXPIRED;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
`endif
                            end else if (r_count == CNT_ZERO) begin
                                // Unreachable zero in RUN: restart the period rather than wrap.
                                r_count <= r_reload;
                            end else begin
                                r_count <= r_count - CNT_ONE;
                            end
                        end else begin
                            r_count <= r_count;
                        end
                    end
                    ST_EXPIRED: begin
                        r_count <= CNT_ZERO;
                    end
                    default: begin
                        r_state   <= ST_IDLE;
                        r_count   <= CNT_ZERO;
                        r_running <= 1'b0;
                        r_done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.count_q = r_count;
    assign bus.running = r_running;
    assign bus.done    = r_done;
    assign bus.tc      = r_tc;
endmodule

// File: tb/tb_down_counter_timer.sv
// Self-checking bench for down_counter_timer: directed vector table, corner sequences, random vs model.
module tb_down_counter_timer;
    localparam int W = 4;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    down_counter_timer_if #(.WIDTH(W)) bus ();

    down_counter_timer #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         ld;
        logic [W-1:0] lv;
        logic         en;
        logic [W-1:0] cnt;
        logic         run;
        logic         dn;
        logic         tc;
    } vec_t;

    vec_t tbl[$];

    // Reference model state: plain integers and flags.
    int m_cnt;
    int m_reload;
    bit m_run;
    bit m_done;
    bit m_tc;

    function automatic logic [W+2:0] obs();
        return {bus.count_q, bus.running, bus.done, bus.tc};
    endfunction

    task automatic check(input string name, input logic [W+2:0] act, input logic [W+2:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d run=%0b done=%0b tc=%0b, expected cnt=%0d run=%0b done=%0b tc=%0b",
                     name, act[W+2:3], act[2], act[1], act[0], exp[W+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step(input logic ld, input logic [W-1:0] lv, input logic en);
        bus.load       = ld;
        bus.load_value = lv;
        bus.enable     = en;
        @(posedge clk);
        #1;
        bus.load   = 1'b0;
        bus.enable = 1'b0;
    endtask

    function automatic void model_step(input bit rst, input bit ld, input int lv, input bit en);
        m_tc = 1'b0;
        if (rst) begin
            m_cnt = 0; m_reload = 0; m_run = 1'b0; m_done = 1'b0;
        end else if (ld) begin
            m_cnt = lv; m_reload = lv;
            m_run = (lv != 0); m_done = (lv == 0);
        end else if (m_run && en) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_tc = 1'b1;
`ifdef AUTO_RELOAD_EN
                m_cnt = m_reload;
`else
                m_run = 1'b0; m_done = 1'b1;
`endif
            end
        end
    endfunction

    function automatic void add(input logic ld, input int lv, input logic en,
                                input int cnt, input logic run, input logic dn, input logic tc);
        vec_t v;
        v.ld = ld; v.lv = lv[W-1:0]; v.en = en;
        v.cnt = cnt[W-1:0]; v.run = run; v.dn = dn; v.tc = tc;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [W+2:0] exp_v;
        bit r_rst;
        bit r_ld;
        int r_lv;
        bit r_en;
        n_checks = 0;
        n_fail   = 0;
        bus.load = 1'b0; bus.load_value = '0; bus.enable = 1'b0;
        reset = 1'b1;
        #2;
        check("reset_state", obs(), {4'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 4'd0, 1'b1);
        check("idle_ignores_enable", obs(), {4'd0, 1'b0, 1'b0, 1'b0});

`ifndef AUTO_RELOAD_EN
        // Load 5 then six enabled edges.
        add(1'b1, 5, 1'b0, 5, 1'b1, 1'b0, 1'b0);
        add(1'b0, 0, 1'b1, 4, 1'b1, 1'b0, 1'b0);
        add(1'b0, 0, 1'b1, 3, 1'b1, 1'b0, 1'b0);
        add(1'b0, 0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b1);
        add(1'b0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        // Load 3, enable pattern 1,0,0,1.
        add(1'b1, 3, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        add(1'b0, 0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
        add(1'b0, 0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
        // Load wins over enable on the same edge.
        add(1'b1, 7, 1'b0, 7, 1'b1, 1'b0, 1'b0);
        add(1'b1, 9, 1'b1, 9, 1'b1, 1'b0, 1'b0);
        add(1'b0, 0, 1'b1, 8, 1'b1, 1'b0, 1'b0);
        // Load of zero expires immediately with no tc.
        add(1'b1, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
`else
        add(1'b1, 3, 1'b0, 3, 1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            add(1'b0, 0, 1'b1, ((k % 3) == 0) ? 3 : 3 - (k % 3), 1'b1, 1'b0, ((k % 3) == 0));
        end
        add(1'b1, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 0, 1'b1, 0, 1'b0, 1'b1, 1'b0);
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].ld, tbl[i].lv, tbl[i].en);
            check($sformatf("vec%0d", i), obs(), {tbl[i].cnt, tbl[i].run, tbl[i].dn, tbl[i].tc});
        end

        // Max load needs exactly 15 enabled edges to terminal count.
        step(1'b1, 4'd15, 1'b0);
        for (int k = 0; k < 14; k++) step(1'b0, 4'd0, 1'b1);
        check("max_load_edge14", obs(), {4'd1, 1'b1, 1'b0, 1'b0});
        step(1'b0, 4'd0, 1'b1);
`ifndef AUTO_RELOAD_EN
        check("max_load_edge15", obs(), {4'd0, 1'b0, 1'b1, 1'b1});
`else
        check("max_load_edge15", obs(), {4'd15, 1'b1, 1'b0, 1'b1});
`endif

        // Reset between edges aborts the count immediately.
        step(1'b1, 4'd12, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b0, 4'd0, 1'b1);
        check("pre_reset_count", obs(), {4'd8, 1'b1, 1'b0, 1'b0});
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", obs(), {4'd0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 4'd0, 1'b1);
            check($sformatf("post_reset%0d", k), obs(), {4'd0, 1'b0, 1'b0, 1'b0});
        end

        // Random stimulus against the reference model.
        model_step(1'b1, 1'b0, 0, 1'b0);
        for (int i = 0; i < 400; i++) begin
            r_rst = ($urandom_range(0, 39) == 0);
            r_ld  = ($urandom_range(0, 7) == 0);
            r_lv  = $urandom_range(0, 15);
            r_en  = $urandom_range(0, 1);
            reset = r_rst;
            step(r_ld, r_lv[W-1:0], r_en);
            model_step(r_rst, r_ld, r_lv, r_en);
            exp_v = {m_cnt[W-1:0], m_run, m_done, m_tc};
            check($sformatf("rand%0d", i), obs(), exp_v);
            reset = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
